// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: SSD1331 power-up, per-frame window re-arm and
// RGB565 pixel streaming over SPI mode 3.
`timescale 1ns/1ps
module oled_frame_streamer #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 1000,
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [12:0] pixel_index,
  input  logic [15:0] pixel_data,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        dc,
  output logic        res_n,
  output logic        vccen,
  output logic        pmoden
);

  localparam int TMAX = (RESET_CYCLES + 1 > CLK_DIV) ?
                        RESET_CYCLES + 1 : CLK_DIV;
  localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_RST  = TW'(RESET_CYCLES);
  localparam logic [TW-1:0] T_WAIT = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_DIV  = TW'(CLK_DIV - 1);
  localparam logic [12:0]   LAST_PIX = 13'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    INIT,
    WINDOW,
    STREAM_START,
    STREAM
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic [3:0]    nxt_cnt;
  logic [3:0]    nxt_bcnt;
  logic [15:0]   shifter;
  logic [15:0]   nxt_word;
  logic          nxt_dc;
  logic          hi_load;
  logic          busy;
  logic          load;

  // WINDOW reuses entries 3..8 of the init table
  function automatic logic [7:0] cmd_byte(input logic [3:0] i);
    case (i)
      4'd0:    cmd_byte = 8'hAE;
      4'd1:    cmd_byte = 8'hA0;
      4'd2:    cmd_byte = 8'h72;
      4'd3:    cmd_byte = 8'h15;
      4'd4:    cmd_byte = 8'h00;
      4'd5:    cmd_byte = 8'h5F;
      4'd6:    cmd_byte = 8'h75;
      4'd7:    cmd_byte = 8'h00;
      4'd8:    cmd_byte = 8'h3F;
      default: cmd_byte = 8'hAF;
    endcase
  endfunction

  assign nxt_cnt = byte_cnt + 4'd1;
  assign busy = (state != RST_LOW) &&
                (state != RST_WAIT);
  assign load = (busy && timer == T_DIV && sclk &&
                 bit_cnt == 3'd7) ||
                (state == RST_WAIT && timer == T_WAIT);

  always_comb begin
    nxt_state = state;
    nxt_bcnt  = nxt_cnt;
    nxt_word  = {cmd_byte(nxt_cnt), 8'h00};
    nxt_dc    = 1'b0;
    hi_load   = 1'b0;
    case (state)
      RST_WAIT: begin
        nxt_state = INIT;
        nxt_bcnt  = 4'd0;
        nxt_word  = {cmd_byte(4'd0), 8'h00};
      end
      INIT:
        if (byte_cnt == 4'd9) hi_load = 1'b1;
      WINDOW:
        if (byte_cnt == 4'd8) hi_load = 1'b1;
      STREAM_START: begin
        nxt_state = STREAM;
        nxt_bcnt  = 4'd1;
        nxt_word  = shifter;
        nxt_dc    = 1'b1;
      end
      STREAM:
        if (!byte_cnt[0]) begin
          nxt_bcnt = 4'd1;
          nxt_word = shifter;
          nxt_dc   = 1'b1;
        end else if (pixel_index == 13'd0) begin
          nxt_state = WINDOW;
          nxt_bcnt  = 4'd3;
          nxt_word  = {cmd_byte(4'd3), 8'h00};
        end else begin
          hi_load = 1'b1;
        end
      default: ;
    endcase
    // low byte is shifted out of the same captured word
    if (hi_load) begin
      nxt_word  = pixel_data;
      nxt_bcnt  = 4'd0;
      nxt_dc    = 1'b1;
      nxt_state = (pixel_index == 13'd0) ?
                  STREAM_START : STREAM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RST_LOW;
      timer          <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      shifter        <= '0;
      pixel_index    <= '0;
      frame_begin    <= 1'b0;
      sending_pixels <= 1'b0;
      cs_n           <= 1'b1;
      sclk           <= 1'b1;
      sdin           <= 1'b0;
      dc             <= 1'b0;
      res_n          <= 1'b0;
      vccen          <= 1'b0;
      pmoden         <= 1'b0;
    end else begin
      frame_begin <= 1'b0;
      if (load) begin
        state          <= nxt_state;
        byte_cnt       <= nxt_bcnt;
        timer          <= '0;
        bit_cnt        <= '0;
        cs_n           <= 1'b0;
        sclk           <= 1'b0;
        sdin           <= nxt_word[15];
        shifter        <= {nxt_word[14:0], 1'b0};
        dc             <= nxt_dc;
        sending_pixels <= nxt_dc;
        if (hi_load) begin
          pixel_index <= (pixel_index == LAST_PIX) ?
                         13'd0 : pixel_index + 13'd1;
          frame_begin <= (pixel_index == 13'd0);
        end
        if (state == INIT && hi_load) vccen <= 1'b1;
      end else begin
        case (state)
          RST_LOW: begin
            pmoden <= 1'b1;
            if (timer == T_RST) begin
              timer <= '0;
              res_n <= 1'b1;
              state <= RST_WAIT;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          RST_WAIT:
            timer <= timer + 1'b1;
          default:
            if (timer != T_DIV) begin
              timer <= timer + 1'b1;
            end else begin
              timer <= '0;
              if (!sclk) begin
                sclk <= 1'b1;
              end else begin
                sclk    <= 1'b0;
                sdin    <= shifter[15];
                shifter <= {shifter[14:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb_oled_frame_streamer: decodes the SPI wire into bytes and compares
// them with a byte-level model of power-up, window and pixel frames.
`timescale 1ns/1ps
module tb_oled_frame_streamer;

  localparam int CLK_DIV   = 2;
  localparam int RST_CYC   = 16;
  localparam int W         = 8;
  localparam int H         = 4;
  localparam int NPIX      = W * H;
  localparam int BYTE_CYC  = 16 * CLK_DIV;
  localparam int FRAME_CYC = (NPIX * 2 + 6) * BYTE_CYC;
  localparam logic [7:0] INIT_SEQ [10] = '{
    8'hAE, 8'hA0, 8'h72, 8'h15, 8'h00,
    8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data = 16'h0;
  logic        frame_begin;
  logic        sending_pixels;
  logic        cs_n;
  logic        sclk;
  logic        sdin;
  logic        dc;
  logic        res_n;
  logic        vccen;
  logic        pmoden;

  oled_frame_streamer #(
    .CLK_DIV(CLK_DIV),
    .RESET_CYCLES(RST_CYC),
    .WIDTH(W),
    .HEIGHT(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pixel_index(pixel_index),
    .pixel_data(pixel_data),
    .frame_begin(frame_begin),
    .sending_pixels(sending_pixels),
    .cs_n(cs_n),
    .sclk(sclk),
    .sdin(sdin),
    .dc(dc),
    .res_n(res_n),
    .vccen(vccen),
    .pmoden(pmoden)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pixel source model: frame 0 constant, frame 1 index, later random
  logic [15:0] mem [NPIX];
  int src_frame = 0;

  function automatic logic [15:0] pix_val(input int f, input int n);
    if (f == 0) return 16'hF81F;
    if (f == 1) return 16'(n);
    return mem[n];
  endfunction

  logic [12:0] idx_q = '0;
  int age = 0;

  // frames >= 3 scribble on pixel_data after each high-byte capture
  always @(posedge clk) begin
    if (pixel_index != idx_q) age <= 0;
    else if (age < 1000) age <= age + 1;
    idx_q <= pixel_index;
    if (src_frame >= 3 && age >= 3 && age < 30)
      pixel_data <= 16'($urandom);
    else
      pixel_data <= pix_val(src_frame, int'(pixel_index));
  end

  // wire monitor
  int cyc = 0;
  int bitn = 0;
  int dc_err = 0;
  int gap_err = 0;
  int fb_count = 0;
  int fb_hi = 0;
  int last_t = 0;
  bit last_ok = 0;
  logic psclk = 1'b1;
  logic bdc = 1'b0;
  logic pfb = 1'b0;
  logic [7:0] sh = '0;
  logic [12:0] pidx = '0;
  logic [9:0] rx [$];
  int fb_t [$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      bitn = 0;
      psclk = 1'b1;
      pfb = 1'b0;
      last_ok = 0;
    end else begin
      if (frame_begin) begin
        fb_hi++;
        if (!pfb) begin
          fb_count++;
          fb_t.push_back(cyc);
        end
      end
      pfb = frame_begin;
      if (pixel_index == 13'd0 && pidx == 13'(NPIX - 1))
        src_frame++;
      pidx = pixel_index;
      if (sclk && !psclk) begin
        if (bitn == 0) bdc = dc;
        else if (dc !== bdc) dc_err++;
        sh = {sh[6:0], sdin};
        bitn++;
        if (bitn == 8) begin
          rx.push_back({sending_pixels, dc, sh});
          bitn = 0;
          if (last_ok && cyc - last_t != BYTE_CYC) gap_err++;
          last_t = cyc;
          last_ok = 1;
        end
      end
      psclk = sclk;
    end
  end

  task automatic expect_byte(input string tag,
                             input logic [7:0] b,
                             input logic d);
    int n = 0;
    logic [9:0] w;
    while (rx.size() == 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rx.size() == 0) begin
      check({tag, " timeout"}, rx.size(), 1);
    end else begin
      w = rx.pop_front();
      check(tag, w, {d, d, b});
    end
  endtask

  task automatic power_up();
    int lo = 0;
    int hi = 0;
    int n = 0;
    bit idle = 1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("pmoden_on", pmoden, 1);
    while (res_n == 1'b0 && n < 100) begin
      lo++;
      @(negedge clk);
      #1;
      n++;
    end
    check("res_n_low_cycles", lo, RST_CYC);
    while (cs_n == 1'b1 && n < 200) begin
      hi++;
      if (!(sclk && !sdin)) idle = 0;
      @(negedge clk);
      #1;
      n++;
    end
    check("res_n_wait_cycles", hi, RST_CYC);
    check("idle_lines", idle, 1);
    check("res_n_high", res_n, 1);
  endtask

  task automatic expect_hdr(input int f, input bit init);
    int k0 = init ? 0 : 3;
    int k1 = init ? 9 : 8;
    for (int k = k0; k <= k1; k++) begin
      expect_byte($sformatf("f%0d cmd%0d", f, k), INIT_SEQ[k], 1'b0);
      check($sformatf("f%0d cmd%0d idx", f, k), pixel_index, 0);
    end
    if (init) check("vccen_before_af_end", vccen, 0);
  endtask

  task automatic expect_pix(input int f, input int count,
                            input int fb_exp);
    logic [15:0] v;
    for (int n = 0; n < count; n++) begin
      v = pix_val(f, n);
      expect_byte($sformatf("f%0d p%0d hi", f, n), v[15:8], 1'b1);
      if (n == 0) begin
        check($sformatf("f%0d vccen", f), vccen, 1);
        check($sformatf("f%0d frame_begin count", f),
              fb_count, fb_exp);
      end
      expect_byte($sformatf("f%0d p%0d lo", f, n), v[7:0], 1'b1);
      if (n == NPIX - 1)
        check($sformatf("f%0d wrap idx", f), pixel_index, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst pixel_index", pixel_index, 0);
    check("rst frame_begin", frame_begin, 0);
    check("rst sending", sending_pixels, 0);
    check("rst cs_n", cs_n, 1);
    check("rst sclk", sclk, 1);
    check("rst sdin", sdin, 0);
    check("rst dc", dc, 0);
    check("rst res_n", res_n, 0);
    check("rst vccen", vccen, 0);
    check("rst pmoden", pmoden, 0);

    power_up();
    expect_hdr(0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      expect_pix(f, NPIX, f + 1);
      expect_hdr(f + 1, 1'b0);
    end
    expect_pix(4, 20, 5);
    check("frame period 0", fb_t[1] - fb_t[0], FRAME_CYC);
    check("frame period 1", fb_t[2] - fb_t[1], FRAME_CYC);
    check("frame period 2", fb_t[3] - fb_t[2], FRAME_CYC);

    n = 0;
    while (pixel_index != 13'd21 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach pixel 20", pixel_index, 21);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst cs_n", cs_n, 1);
    check("midrst sclk", sclk, 1);
    check("midrst res_n", res_n, 0);
    check("midrst vccen", vccen, 0);
    check("midrst pixel_index", pixel_index, 0);
    check("midrst pmoden", pmoden, 0);
    check("midrst dc", dc, 0);
    repeat (3) @(negedge clk);
    #1;
    rx.delete();

    power_up();
    expect_hdr(5, 1'b1);
    expect_pix(4, NPIX, 6);
    expect_hdr(6, 1'b0);

    check("dc stable in byte", dc_err, 0);
    check("byte spacing", gap_err, 0);
    check("frame_begin width", fb_hi, fb_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
